// File: rtl/axi_lite_slave_regs.sv
// AXI4-Lite register responder: NUM_REGS 32-bit read/write registers with
// independent write (AW/W/B) and read (AR/R) paths and a flat register output.
// Out-of-range accesses answer DECERR and leave every register untouched.
module axi_lite_slave_regs #(
  parameter int          NUM_REGS  = 8,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [31:0]              awaddr,
  input  logic                     awvalid,
  output logic                     awready,
  input  logic [31:0]              wdata,
  input  logic [3:0]               wstrb,
  input  logic                     wvalid,
  output logic                     wready,
  output logic [1:0]               bresp,
  output logic                     bvalid,
  input  logic                     bready,
  input  logic [31:0]              araddr,
  input  logic                     arvalid,
  output logic                     arready,
  output logic [31:0]              rdata,
  output logic [1:0]               rresp,
  output logic                     rvalid,
  input  logic                     rready,
  output logic [NUM_REGS*32-1:0]   regs_o
);

  localparam int         IDX_W       = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  // Address lies at or above the base and its word index falls inside the file.
  function automatic logic addr_hit(input logic [31:0] addr);
    return (addr >= BASE_ADDR) && (((addr - BASE_ADDR) >> 2) < 32'(NUM_REGS));
  endfunction

  // Word index of an address; byte-lane bits are dropped.
  function automatic logic [IDX_W-1:0] addr_idx(input logic [31:0] addr);
    return IDX_W'((addr - BASE_ADDR) >> 2);
  endfunction

  logic [31:0] regs_q [NUM_REGS];
  logic [31:0] regs_d [NUM_REGS];

  logic        aw_held_q, aw_held_d;
  logic [31:0] aw_addr_q, aw_addr_d;
  logic        w_held_q,  w_held_d;
  logic [31:0] w_data_q,  w_data_d;
  logic [3:0]  w_strb_q,  w_strb_d;
  logic        bvalid_q,  bvalid_d;
  logic [1:0]  bresp_q,   bresp_d;

  logic        rvalid_q,  rvalid_d;
  logic [31:0] rdata_q,   rdata_d;
  logic [1:0]  rresp_q,   rresp_d;

  logic             aw_hs, w_hs, ar_hs, commit;
  logic [31:0]      wr_addr, wr_data;
  logic [3:0]       wr_strb;
  logic             wr_hit, rd_hit;
  logic [IDX_W-1:0] wr_idx, rd_idx;

  // Ready only while nothing is parked on the channel and no response is pending.
  assign awready = !aw_held_q && !bvalid_q;
  assign wready  = !w_held_q  && !bvalid_q;
  assign arready = !rvalid_q;

  assign aw_hs = awvalid && awready;
  assign w_hs  = wvalid  && wready;
  assign ar_hs = arvalid && arready;

  // A write commits on the edge where both halves are either parked or arriving.
  assign commit  = (aw_held_q || aw_hs) && (w_held_q || w_hs);
  assign wr_addr = aw_held_q ? aw_addr_q : awaddr;
  assign wr_data = w_held_q  ? w_data_q  : wdata;
  assign wr_strb = w_held_q  ? w_strb_q  : wstrb;
  assign wr_hit  = addr_hit(wr_addr);
  assign wr_idx  = addr_idx(wr_addr);

  assign rd_hit  = addr_hit(araddr);
  assign rd_idx  = addr_idx(araddr);

  // Write path: capture AW/W independently, commit byte lanes, raise B response.
  always_comb begin
    regs_d    = regs_q;
    aw_held_d = aw_held_q;
    aw_addr_d = aw_addr_q;
    w_held_d  = w_held_q;
    w_data_d  = w_data_q;
    w_strb_d  = w_strb_q;
    bvalid_d  = bvalid_q;
    bresp_d   = bresp_q;

    if (bvalid_q && bready) begin
      bvalid_d = 1'b0;
    end

    if (commit) begin
      if (wr_hit) begin
        for (int b = 0; b < 4; b++) begin
          if (wr_strb[b]) begin
            regs_d[wr_idx][8*b +: 8] = wr_data[8*b +: 8];
          end
        end
      end
      bvalid_d  = 1'b1;
      bresp_d   = wr_hit ? RESP_OKAY : RESP_DECERR;
      aw_held_d = 1'b0;
      w_held_d  = 1'b0;
    end else begin
      if (aw_hs) begin
        aw_held_d = 1'b1;
        aw_addr_d = awaddr;
      end
      if (w_hs) begin
        w_held_d = 1'b1;
        w_data_d = wdata;
        w_strb_d = wstrb;
      end
    end
  end

  // Read path: sample the pre-write register value so a colliding write reads old.
  always_comb begin
    rvalid_d = rvalid_q;
    rdata_d  = rdata_q;
    rresp_d  = rresp_q;

    if (rvalid_q && rready) begin
      rvalid_d = 1'b0;
    end

    if (ar_hs) begin
      rvalid_d = 1'b1;
      rdata_d  = rd_hit ? regs_q[rd_idx] : 32'h0;
      rresp_d  = rd_hit ? RESP_OKAY : RESP_DECERR;
    end
  end

  // State registers with synchronous reset; reset abandons any in-flight transfer.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= '0;
      end
      aw_held_q <= 1'b0;
      aw_addr_q <= '0;
      w_held_q  <= 1'b0;
      w_data_q  <= '0;
      w_strb_q  <= '0;
      bvalid_q  <= 1'b0;
      bresp_q   <= RESP_OKAY;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
      rresp_q   <= RESP_OKAY;
    end else begin
      regs_q    <= regs_d;
      aw_held_q <= aw_held_d;
      aw_addr_q <= aw_addr_d;
      w_held_q  <= w_held_d;
      w_data_q  <= w_data_d;
      w_strb_q  <= w_strb_d;
      bvalid_q  <= bvalid_d;
      bresp_q   <= bresp_d;
      rvalid_q  <= rvalid_d;
      rdata_q   <= rdata_d;
      rresp_q   <= rresp_d;
    end
  end

  assign bvalid = bvalid_q;
  assign bresp  = bresp_q;
  assign rvalid = rvalid_q;
  assign rdata  = rdata_q;
  assign rresp  = rresp_q;

  for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_regs_o
    assign regs_o[32*gi +: 32] = regs_q[gi];
  end

endmodule

// File: tb/tb_axi_lite_slave_regs.sv
// Scoreboard bench for axi_lite_slave_regs: tasks drive AXI-Lite transfers and
// push expected B/R responses; a monitor pops and compares on each handshake.
module tb_axi_lite_slave_regs;

  localparam int          NR   = 8;
  localparam logic [31:0] BASE = 32'h0000_0000;

  logic             clk, rst;
  logic [31:0]      awaddr, wdata, araddr, rdata;
  logic             awvalid, awready, wvalid, wready, bvalid, bready;
  logic             arvalid, arready, rvalid, rready;
  logic [3:0]       wstrb;
  logic [1:0]       bresp, rresp;
  logic [NR*32-1:0] regs_o;

  axi_lite_slave_regs #(.NUM_REGS(NR), .BASE_ADDR(BASE)) dut (
    .clk(clk), .rst(rst),
    .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .araddr(araddr), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
    .regs_o(regs_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] data;
    logic [1:0]  resp;
  } rexp_t;

  int          n_vec = 0;
  int          n_err = 0;
  logic [31:0] model [NR];
  logic [1:0]  exp_b [$];
  rexp_t       exp_r [$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit m_hit(input logic [31:0] a);
    return (a >= BASE) && (((a - BASE) / 4) < NR);
  endfunction

  function automatic int m_idx(input logic [31:0] a);
    return int'((a - BASE) / 4);
  endfunction

  function automatic logic [31:0] rand_addr();
    int k;
    k = $urandom_range(0, 9);
    if (k == 9) return 32'hFFFF_FFF0 + 32'($urandom_range(0, 3));
    return 32'(k * 4 + $urandom_range(0, 3));
  endfunction

  task automatic check_regs();
    for (int i = 0; i < NR; i++) check("regs_o", regs_o[32*i +: 32], model[i]);
  endtask

  // Monitor: every completed B/R handshake is matched against the scoreboard.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (bvalid && bready) begin
          if (exp_b.size() == 0) check("b_unexpected", 1, 0);
          else check("bresp", bresp, exp_b.pop_front());
        end
        if (rvalid && rready) begin
          if (exp_r.size() == 0) check("r_unexpected", 1, 0);
          else begin
            rexp_t e;
            e = exp_r.pop_front();
            check("rdata", rdata, e.data);
            check("rresp", rresp, e.resp);
          end
        end
      end
    end
  end

  // Starts and ends at posedge+1.
  task automatic do_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                          input int aw_dly, input int w_dly, input int b_dly);
    bit         ok_a, ok_w;
    logic [1:0] r;
    ok_a   = 0;
    ok_w   = 0;
    bready = 1'b0;
    fork
      begin
        if (aw_dly > 0) begin
          repeat (aw_dly) @(posedge clk);
          #1;
        end
        awaddr  = addr;
        awvalid = 1'b1;
        for (int i = 0; i < 50 && !ok_a; i++) begin
          @(negedge clk);
          ok_a = awready;
          if (ok_a && ok_w) check("wready_while_held", wready, 0);
          @(posedge clk);
          #1;
        end
        awvalid = 1'b0;
      end
      begin
        if (w_dly > 0) begin
          repeat (w_dly) @(posedge clk);
          #1;
        end
        wdata  = data;
        wstrb  = strb;
        wvalid = 1'b1;
        for (int i = 0; i < 50 && !ok_w; i++) begin
          @(negedge clk);
          ok_w = wready;
          @(posedge clk);
          #1;
        end
        wvalid = 1'b0;
      end
    join
    check("aw_accept", ok_a, 1);
    check("w_accept", ok_w, 1);
    r = m_hit(addr) ? 2'b00 : 2'b11;
    if (m_hit(addr)) begin
      for (int b = 0; b < 4; b++)
        if (strb[b]) model[m_idx(addr)][8*b +: 8] = data[8*b +: 8];
    end
    exp_b.push_back(r);
    @(negedge clk);
    check("b_latency", bvalid, 1);
    check_regs();
    for (int i = 0; i < b_dly; i++) begin
      @(posedge clk);
      #1;
      @(negedge clk);
      check("bvalid_hold", bvalid, 1);
      check("bresp_hold", bresp, r);
      check("awready_busy", awready, 0);
    end
    @(posedge clk);
    #1;
    bready = 1'b1;
    @(posedge clk);
    #1;
    bready = 1'b0;
    @(negedge clk);
    check("bvalid_drop", bvalid, 0);
    check("awready_back", awready, 1);
    check("wready_back", wready, 1);
    @(posedge clk);
    #1;
  endtask

  // Expected read value is taken from the model at the negedge before the AR edge,
  // so a write committing on that same edge is not yet visible.
  task automatic do_read(input logic [31:0] addr, input int r_dly);
    bit    ok;
    rexp_t e;
    ok      = 0;
    e.data  = '0;
    e.resp  = '0;
    rready  = 1'b0;
    araddr  = addr;
    arvalid = 1'b1;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk);
      ok = arready;
      if (ok) begin
        e.data = m_hit(addr) ? model[m_idx(addr)] : 32'h0;
        e.resp = m_hit(addr) ? 2'b00 : 2'b11;
        exp_r.push_back(e);
      end
      @(posedge clk);
      #1;
    end
    arvalid = 1'b0;
    check("ar_accept", ok, 1);
    @(negedge clk);
    check("r_latency", rvalid, 1);
    check("arready_busy", arready, 0);
    for (int i = 0; i < r_dly; i++) begin
      @(posedge clk);
      #1;
      @(negedge clk);
      check("rvalid_hold", rvalid, 1);
      check("rdata_hold", rdata, e.data);
      check("arready_hold", arready, 0);
    end
    @(posedge clk);
    #1;
    rready = 1'b1;
    @(posedge clk);
    #1;
    rready = 1'b0;
    @(negedge clk);
    check("rvalid_drop", rvalid, 0);
    check("arready_back", arready, 1);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] aw, ar;
    rst = 1'b1;
    awaddr = '0; awvalid = 0; wdata = '0; wstrb = '0; wvalid = 0; bready = 0;
    araddr = '0; arvalid = 0; rready = 0;
    for (int i = 0; i < NR; i++) model[i] = '0;

    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_awready", awready, 1);
    check("rst_wready", wready, 1);
    check("rst_arready", arready, 1);
    check("rst_bvalid", bvalid, 0);
    check("rst_rvalid", rvalid, 0);
    check("rst_bresp", bresp, 0);
    check("rst_rresp", rresp, 0);
    check("rst_rdata", rdata, 0);
    check_regs();
    @(posedge clk);
    #1;
    rst = 1'b0;

    do_write(32'h4, 32'hDEADBEEF, 4'hF, 0, 0, 0);
    check("reg1_value", regs_o[63:32], 32'hDEADBEEF);

    do_write(32'h8, 32'hAABBCCDD, 4'hF, 0, 0, 0);
    do_write(32'h8, 32'h11223344, 4'b0101, 2, 0, 1);
    check("reg2_merge", regs_o[95:64], 32'hAA22CC44);

    do_read(32'h4, 3);

    do_write(32'h20, 32'h1234_5678, 4'hF, 0, 0, 0);
    do_read(32'h20, 0);

    fork
      do_write(32'h0, 32'h5, 4'hF, 0, 0, 0);
      do_read(32'h0, 0);
    join
    do_read(32'h0, 1);
    check("reg0_value", regs_o[31:0], 32'h5);

    do_write(32'h1C, 32'hCAFE_F00D, 4'h0, 0, 0, 0);

    for (int it = 0; it < 80; it++) begin
      aw = rand_addr();
      ar = rand_addr();
      case ($urandom_range(0, 2))
        0: do_write(aw, $urandom, 4'($urandom), $urandom_range(0, 2), $urandom_range(0, 2),
                    $urandom_range(0, 2));
        1: do_read(ar, $urandom_range(0, 2));
        default: begin
          fork
            do_write(aw, $urandom, 4'($urandom), $urandom_range(0, 2), $urandom_range(0, 2),
                     $urandom_range(0, 2));
            do_read(ar, $urandom_range(0, 2));
          join
        end
      endcase
    end
    check("b_queue_empty", exp_b.size(), 0);
    check("r_queue_empty", exp_r.size(), 0);

    awaddr  = 32'hC;
    awvalid = 1'b1;
    wdata   = 32'h0BAD_0BAD;
    wstrb   = 4'hF;
    wvalid  = 1'b1;
    bready  = 1'b0;
    @(posedge clk);
    #1;
    awvalid = 1'b0;
    wvalid  = 1'b0;
    @(negedge clk);
    check("pre_rst_bvalid", bvalid, 1);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    for (int i = 0; i < NR; i++) model[i] = '0;
    @(negedge clk);
    check("midrst_bvalid", bvalid, 0);
    check("midrst_awready", awready, 1);
    check("midrst_wready", wready, 1);
    check("midrst_arready", arready, 1);
    check_regs();
    @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("no_b_after_rst", bvalid, 0);
    do_read(32'hC, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/axi_lite_slave_regs.md
Name: axi_lite_slave_regs

Overview:
- AXI4-Lite responder (slave) exposing NUM_REGS 32-bit read/write registers on the axi_pkg bus.
- Sits at the far end of an axi_lite_bus_t from an initiator and answers all five channels.
- Register contents are presented to fabric logic on a flat output vector.
- Write and read paths are independent and may be active simultaneously.

Parameters:
- NUM_REGS, 8, number of 32-bit registers (1..256).
- BASE_ADDR, 32'h0000_0000, byte address of register 0; must be 4-byte aligned.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- awaddr  in  32  write address (axi_pkg addr_t).
- awvalid  in  1 / awready  out  1  write-address handshake.
- wdata  in  32 / wstrb  in  4  write data and byte strobes (data_t, strb_t).
- wvalid  in  1 / wready  out  1  write-data handshake.
- bresp  out  2 / bvalid  out  1 / bready  in  1  write response (resp_t).
- araddr  in  32 / arvalid  in  1 / arready  out  1  read-address channel.
- rdata  out  32 / rresp  out  2 / rvalid  out  1 / rready  in  1  read data channel.
- regs_o  out  NUM_REGS*32  register i occupies bits [32*i+31:32*i].

Behaviour:
- Reset, sampled synchronously on rst=1: all registers 0, awready=1, wready=1, arready=1, bvalid=0, rvalid=0, bresp=OKAY, rresp=OKAY, rdata=0, and all capture flags cleared. Reset asserted mid-transaction abandons it; no response is issued afterwards.
- Decode: off = addr - BASE_ADDR; idx = off[31:2]; addr[1:0] ignored.
  - Hit if addr >= BASE_ADDR and idx < NUM_REGS.
  - Otherwise the response is DECERR (2'b11) and no state changes.
- Write path, with capture flags aw_held and w_held:
  - awready = !aw_held && !bvalid. wready = !w_held && !bvalid.
  - An AW handshake latches awaddr and sets aw_held. A W handshake latches wdata/wstrb and sets w_held. AW and W may arrive in either order or in the same cycle.
  - On the edge where both are held (or become held), the write commits:
    - for each byte b with wstrb[b]=1, reg[idx][8b+7:8b] <= wdata[8b+7:8b];
    - bvalid <= 1; bresp <= OKAY on hit, DECERR on miss;
    - both flags clear.
  - Latency: AW and W accepted in cycle k → regs_o updated and bvalid=1 in cycle k+1.
  - bvalid holds with stable bresp until bready=1, then drops next cycle; awready/wready return high the same cycle.
  - wstrb=0 on a hit: OKAY response, no change.
- Read path:
  - arready = !rvalid.
  - AR handshake in cycle k → rvalid=1 in cycle k+1 with rdata=reg[idx] sampled at edge k and rresp=OKAY. On a miss, rdata=0 and rresp=DECERR.
  - rdata/rresp stay stable while rvalid && !rready. Handshake → rvalid=0 next cycle and arready=1.
- Read/write collision: when an AR handshake and a write commit to the same register hit the same edge, the read returns the old value.
- Valid-before-ready: the block never waits on bready/rready to assert valid. Inputs are only sampled when their handshake completes.
- Max throughput: one write per 2 cycles, one read per 2 cycles, reads and writes concurrent.
- EXOKAY and SLVERR are never generated.

Test Plan:
- Reset, then AW=0x4 and W=0xDEADBEEF with wstrb=4'hF in the same cycle, bready=1 → bvalid in the next cycle with bresp=00; regs_o[63:32]=0xDEADBEEF.
- W 0x11223344 with strb=4'b0101 two cycles before AW 0x8, over reg2=0xAABBCCDD → AW accepted while wready=0; final reg2=0xAA22CC44, one B response with OKAY.
- AR 0x4 with rready=0 for 3 cycles → rvalid stays 1, rdata stays 0xDEADBEEF, arready=0; rready=1 → rvalid=0 next cycle, arready=1.
- AW 0x20 with NUM_REGS=8 → bresp=11 and no register changes; AR 0x20 → rresp=11, rdata=0.
- AR and write to 0x0 (data 0x5) committing on the same edge, reg0=0 beforehand → rdata=0, then a subsequent read of 0x0 returns 0x5.
- rst=1 asserted while bvalid=1 is waiting on bready=0 → bvalid=0, all regs 0, awready=wready=arready=1 on the next cycle.
